// File: rtl/exc_ctrl_pkg.sv
// Shared types and constants for the exception controller: FSM encoding,
// ExcCode values and CP0 Status/Cause bit positions.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;

    localparam int STATUS_IE    = 0;
    localparam int STATUS_EXL   = 1;
    localparam int STATUS_ERL   = 2;
    localparam int STATUS_IM_LO = 8;
    localparam int STATUS_BEV   = 22;

    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 8;
    localparam int CAUSE_BD     = 31;

endpackage

// File: rtl/exc_ctrl_if.sv
// Pipeline <-> exception controller signal bundle; slave is the controller side.
interface exc_ctrl_if;

    logic [31:0] status_q;
    logic [5:0]  hw_int;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic        eret;
    logic        cause_we;
    logic        epc_we;
    logic [31:0] mtcd;
    logic        exl_next;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] cause_q;
    logic [31:0] epc_q;
    logic        busy;

    modport slave (
        input  status_q, hw_int, exc_req, exc_code, exc_pc, exc_bd, eret,
               cause_we, epc_we, mtcd,
        output exl_next, flush, redirect, redirect_pc, cause_q, epc_q, busy
    );

    modport master (
        output status_q, hw_int, exc_req, exc_code, exc_pc, exc_bd, eret,
               cause_we, epc_we, mtcd,
        input  exl_next, flush, redirect, redirect_pc, cause_q, epc_q, busy
    );

endinterface

// File: rtl/exc_ctrl_int_sync.sv
// Multi-flop synchronizer bringing the asynchronous interrupt lines into clk.
module int_sync #(
    parameter int WIDTH  = 6,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // NOTE: sequential state uses non-blocking assignment so every stage
    // samples the previous stage's old value, forming a real shift chain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// CP0 exception/interrupt controller: accepts one event in IDLE, captures
// EPC/Cause, then issues a one-cycle flush followed by a one-cycle redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_NORMAL  = 32'h8000_0180,
    parameter logic [31:0] VEC_BOOT    = 32'hBFC0_0380,
    parameter int          SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    exc_ctrl_if.slave  bus
);

    state_t      state;
    logic [5:0]  hw_ip;
    logic [1:0]  ip_sw;
    logic [7:0]  ip;
    logic [7:0]  im;
    logic        int_pend;
    logic        idle;
    logic        take_exc;
    logic        take_int;
    logic        take_trap;
    logic        take_eret;
    logic        cause_bd;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic        flush;
    logic        redirect;
    logic        busy;
    logic [31:0] redirect_pc;

    int_sync #(
        .WIDTH  (6),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.hw_int),
        .q   (hw_ip)
    );

    assign ip = {hw_ip, ip_sw};
    assign im = bus.status_q[STATUS_IM_LO +: 8];

    assign int_pend = bus.status_q[STATUS_IE] & ~bus.status_q[STATUS_EXL] &
                      ~bus.status_q[STATUS_ERL] & (|(ip & im));

    // Acceptance priority: exception, then interrupt, then eret.
    assign idle      = (state == ST_IDLE);
    assign take_exc  = idle & bus.exc_req;
    assign take_int  = idle & ~bus.exc_req & int_pend;
    assign take_trap = take_exc | take_int;
    assign take_eret = idle & ~bus.exc_req & ~int_pend & bus.eret;

    // NOTE: every branch of this selector assigns a value, so no latch can form.
    assign bus.exl_next = take_trap ? 1'b1 :
                          take_eret ? 1'b0 : bus.status_q[STATUS_EXL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            flush       <= 1'b0;
            redirect    <= 1'b0;
            busy        <= 1'b0;
            redirect_pc <= '0;
            epc         <= '0;
            cause_bd    <= 1'b0;
            cause_exc   <= EXC_INT;
            ip_sw       <= 2'b00;
        end else begin
            if (bus.cause_we) ip_sw <= bus.mtcd[9:8];

            // A nested trap (EXL already set) keeps the original EPC and BD.
            if (take_trap && !bus.status_q[STATUS_EXL]) begin
                epc      <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                cause_bd <= bus.exc_bd;
            end else if (bus.epc_we) begin
                epc <= bus.mtcd;
            end

            unique case (state)
                ST_IDLE: begin
                    if (take_trap) begin
                        cause_exc   <= take_exc ? bus.exc_code : EXC_INT;
                        redirect_pc <= bus.status_q[STATUS_BEV] ? VEC_BOOT : VEC_NORMAL;
                    end else if (take_eret) begin
                        redirect_pc <= epc;
                    end
                    if (take_trap || take_eret) begin
                        state <= ST_FLUSH;
                        flush <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    state    <= ST_REDIRECT;
                    flush    <= 1'b0;
                    redirect <= 1'b1;
                end
                ST_REDIRECT: begin
                    state    <= ST_IDLE;
                    redirect <= 1'b0;
                    busy     <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    flush    <= 1'b0;
                    redirect <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.flush       = flush;
    assign bus.redirect    = redirect;
    assign bus.busy        = busy;
    assign bus.redirect_pc = redirect_pc;
    assign bus.epc_q       = epc;
    assign bus.cause_q     = {cause_bd, 15'b0, ip, 1'b0, cause_exc, 2'b00};

endmodule
